// File: rtl/memory_responder.sv
// Byte-addressed memory responder for the cache miss/write-through channel (four-phase handshake).
// Define MEM_RESPONDER_SNOOP_EN to add the external write port that drives cache invalidation.
module memory_responder #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned READ_LATENCY   = 2,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [24:0] memory_request,
    input  logic        memory_request_ready,
    output logic [15:0] memory_response,
    output logic        memory_response_ready,
    output logic        busy,
    output logic [15:0] invalidate_address,
    output logic        invalidate_valid
`ifdef MEM_RESPONDER_SNOOP_EN
    ,
    input  logic        ext_write,
    input  logic [15:0] ext_address,
    input  logic [7:0]  ext_data
`endif
);
    localparam int unsigned BLK_W    = ADDR_WIDTH - 1;
    localparam int unsigned NUM_BLK  = 2 ** BLK_W;
    localparam int unsigned CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned CNT_INIT = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESPOND} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [BLK_W-1:0] r_clr_blk, w_clr_blk_nxt;
    logic [BLK_W-1:0] r_blk, w_blk_nxt;
    logic [15:0]      r_rsp, w_rsp_nxt;
    logic             r_rsp_vld, w_rsp_vld_nxt;
    logic             r_busy, w_busy_nxt;
    logic             w_clr_we, w_req_we;
    logic [BLK_W-1:0] w_req_blk;
    logic             w_req_hi;
    logic [7:0]       w_req_data;

    // Store organised as 16-bit blocks with byte writes; the clear writes a whole block per cycle.
    logic [15:0] r_mem [NUM_BLK];

    assign w_req_blk  = memory_request[ADDR_WIDTH-1:1];
    assign w_req_hi   = memory_request[0];
    assign w_req_data = memory_request[23:16];

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_clr_blk_nxt = r_clr_blk;
        w_blk_nxt     = r_blk;
        w_rsp_nxt     = r_rsp;
        w_rsp_vld_nxt = r_rsp_vld;
        w_busy_nxt    = r_busy;
        w_clr_we      = 1'b0;
        w_req_we      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_blk_nxt = r_clr_blk + BLK_W'(1);
                if (r_clr_blk == BLK_W'(NUM_BLK - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            S_IDLE: begin
                if (memory_request_ready) begin
                    w_blk_nxt   = w_req_blk;
                    w_req_we    = memory_request[24];
                    w_cnt_nxt   = CNT_W'(CNT_INIT);
                    w_state_nxt = (READ_LATENCY > 0) ? S_WAIT : S_RESPOND;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESPOND;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RESPOND: begin
                // Read once on entry so the response stays stable while the request is held.
                if (!r_rsp_vld) begin
                    w_rsp_nxt     = r_mem[r_blk];
                    w_rsp_vld_nxt = 1'b1;
                end else if (!memory_request_ready) begin
                    w_rsp_nxt     = '0;
                    w_rsp_vld_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_busy    <= (CLEAR_ON_RESET != 0);
            r_cnt     <= '0;
            r_clr_blk <= '0;
            r_blk     <= '0;
            r_rsp     <= '0;
            r_rsp_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clr_blk <= w_clr_blk_nxt;
            r_blk     <= w_blk_nxt;
            r_rsp     <= w_rsp_nxt;
            r_rsp_vld <= w_rsp_vld_nxt;
        end
    end

`ifdef MEM_RESPONDER_SNOOP_EN
    logic             w_ext_we;
    logic [BLK_W-1:0] w_ext_blk;
    logic [15:0]      r_inv_addr;
    logic             r_inv_vld;

    assign w_ext_we  = ext_write && !r_busy;
    assign w_ext_blk = ext_address[ADDR_WIDTH-1:1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_inv_addr <= '0;
            r_inv_vld  <= 1'b0;
        end else begin
            r_inv_vld <= w_ext_we;
            if (w_ext_we) begin
                r_inv_addr <= {ext_address[15:1], 1'b0};
            end
        end
    end

    assign invalidate_address = r_inv_addr;
    assign invalidate_valid   = r_inv_vld;
`else
    assign invalidate_address = '0;
    assign invalidate_valid   = 1'b0;
`endif

    // Store writes; the cache write is last so it wins a same-byte collision with the external agent.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_clr_we) begin
                r_mem[r_clr_blk] <= '0;
            end
`ifdef MEM_RESPONDER_SNOOP_EN
            if (w_ext_we) begin
                if (ext_address[0]) r_mem[w_ext_blk][15:8] <= ext_data;
                else                r_mem[w_ext_blk][7:0]  <= ext_data;
            end
`endif
            if (w_req_we) begin
                if (w_req_hi) r_mem[w_req_blk][15:8] <= w_req_data;
                else          r_mem[w_req_blk][7:0]  <= w_req_data;
            end
        end
    end

    assign memory_response       = r_rsp;
    assign memory_response_ready = r_rsp_vld;
    assign busy                  = r_busy;

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: four instances with different latency/size/clear settings.
module tb_memory_responder;
    localparam int NDUT = 4;
    localparam logic [31:0] NOCHK = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        chk_data;
        logic [15:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [24:0] req     [NDUT];
    logic        req_rdy [NDUT];
    logic [15:0] rsp     [NDUT];
    logic        rsp_vld [NDUT];
    logic        busy_s  [NDUT];
    logic [15:0] inv_a   [NDUT];
    logic        inv_v   [NDUT];
    logic        ext_we  [NDUT];
    logic [15:0] ext_a   [NDUT];
    logic [7:0]  ext_d   [NDUT];

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    exp_t        exp_q   [NDUT][$];
    logic [15:0] cur     [NDUT];
    logic        cur_chk [NDUT];
    logic        prev_vld[NDUT];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        memory_responder #(
            .ADDR_WIDTH    (g == 3 ? 16 : 8),
            .READ_LATENCY  (g == 0 ? 2 : g == 1 ? 0 : g == 2 ? 5 : 1),
            .CLEAR_ON_RESET(g == 3 ? 0 : 1)
        ) u_dut (
            .clock                (clock),
            .reset                (reset),
            .memory_request       (req[g]),
            .memory_request_ready (req_rdy[g]),
            .memory_response      (rsp[g]),
            .memory_response_ready(rsp_vld[g]),
            .busy                 (busy_s[g]),
            .invalidate_address   (inv_a[g]),
            .invalidate_valid     (inv_v[g])
`ifdef MEM_RESPONDER_SNOOP_EN
            ,
            .ext_write            (ext_we[g]),
            .ext_address          (ext_a[g]),
            .ext_data             (ext_d[g])
`endif
        );
    end

    function automatic int rl_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : (d == 2) ? 5 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on each rising response-ready, then watches stability and clearing.
    always @(negedge clock) begin : mon
        exp_t e;
        for (int d = 0; d < NDUT; d++) begin
            if (rsp_vld[d] === 1'b1 && prev_vld[d] !== 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp_d%0d: got %0h expected none", d, rsp[d]);
                    cur_chk[d] = 1'b0;
                end else begin
                    e = exp_q[d].pop_front();
                    cur[d]     = e.data;
                    cur_chk[d] = e.chk_data;
                    if (e.chk_data) chk($sformatf("rsp_data_d%0d", d), 32'(rsp[d]), 32'(e.data));
                    if (e.cyc != NOCHK) chk($sformatf("rsp_latency_d%0d", d), cyc, e.cyc);
                end
            end else if (rsp_vld[d] === 1'b1) begin
                if (cur_chk[d]) chk($sformatf("rsp_stable_d%0d", d), 32'(rsp[d]), 32'(cur[d]));
            end else if (prev_vld[d] === 1'b1) begin
                chk($sformatf("rsp_cleared_d%0d", d), 32'(rsp[d]), 0);
            end
            prev_vld[d] = rsp_vld[d];
        end
    end

    // Issue one four-phase transaction; called and returns on a falling edge.
    task automatic txn(input int d, input logic we, input logic [7:0] data, input logic [15:0] addr,
                       input logic chk_data, input logic [15:0] exp, input int hold);
        exp_t e;
        int   n;
        e.chk_data = chk_data;
        e.data     = exp;
        e.cyc      = busy_s[d] ? NOCHK : 32'(cyc + 2 + 32'(rl_of(d)));
        exp_q[d].push_back(e);
        req[d]     = {we, data, addr};
        req_rdy[d] = 1'b1;
        @(negedge clock);
        if (e.cyc != NOCHK) req[d] = ~req[d];
        n = 0;
        while (rsp_vld[d] !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (rsp_vld[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout_d%0d: got no response expected %0h", d, exp);
            if (exp_q[d].size() > 0) e = exp_q[d].pop_back();
        end
        repeat (hold) @(negedge clock);
        req_rdy[d] = 1'b0;
        @(negedge clock);
        chk($sformatf("drop_d%0d", d), 32'(rsp_vld[d]), 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            req[d] = '0; req_rdy[d] = 1'b0; ext_we[d] = 1'b0; ext_a[d] = '0; ext_d[d] = '0;
            cur[d] = '0; cur_chk[d] = 1'b0; prev_vld[d] = 1'b0;
        end
        repeat (2) @(negedge clock);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset_rsp_d%0d", d), 32'(rsp[d]), 0);
            chk($sformatf("reset_vld_d%0d", d), 32'(rsp_vld[d]), 0);
            chk($sformatf("reset_busy_d%0d", d), 32'(busy_s[d]), (d == 3) ? 0 : 1);
            chk($sformatf("reset_inv_d%0d", d), {15'd0, inv_v[d], inv_a[d]}, 0);
        end
        reset = 1'b0;

        // Clear length for ADDR_WIDTH=8: 128 cycles of busy
        n = 0;
        while (busy_s[0] === 1'b1 && n < 1000) begin
            n++;
            @(negedge clock);
        end
        chk("clear_cycles_d0", n, 128);
        chk("clear_done_d1", 32'(busy_s[1]), 0);
        chk("clear_done_d2", 32'(busy_s[2]), 0);

        for (int a = 0; a < 256; a++) txn(0, 1'b0, 8'h00, 16'(a), 1'b1, 16'h0000, 0);

        for (int d = 0; d < 3; d++) begin
            txn(d, 1'b1, 8'd55, 16'd12, 1'b1, 16'h0037, 0);
            txn(d, 1'b0, 8'h00, 16'd13, 1'b1, 16'h0037, 0);
        end
        txn(0, 1'b0, 8'h00, 16'd12, 1'b1, 16'h0037, 10);
        txn(2, 1'b1, 8'hC3, 16'd13, 1'b1, 16'hC337, 3);

        // Top of a 64 KiB store: upper-byte placement, no wrap
        txn(3, 1'b1, 8'h00, 16'hFFFE, 1'b0, 16'h0000, 0);
        txn(3, 1'b1, 8'h22, 16'hFFFF, 1'b1, 16'h2200, 0);
        txn(3, 1'b0, 8'h00, 16'hFFFE, 1'b1, 16'h2200, 0);
        txn(3, 1'b0, 8'h00, 16'hFFFF, 1'b1, 16'h2200, 2);

        // Reset in the middle of a read's wait states
        txn(0, 1'b1, 8'hA5, 16'h0020, 1'b1, 16'h00A5, 0);
        exp_q[0].push_back('{chk_data: 1'b1, data: 16'h0000, cyc: NOCHK});
        req[0]     = {1'b0, 8'h00, 16'h0020};
        req_rdy[0] = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_wait_busy_d0", 32'(busy_s[0]), 1);
        chk("rst_wait_vld_d0", 32'(rsp_vld[0]), 0);
        n = 0;
        while (rsp_vld[0] !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("rst_wait_served_after_clear_d0", 32'(n > 127), 1);
        req_rdy[0] = 1'b0;
        @(negedge clock);
        chk("rst_wait_drop_d0", 32'(rsp_vld[0]), 0);
        while (busy_s[1] === 1'b1 || busy_s[2] === 1'b1) @(negedge clock);

`ifdef MEM_RESPONDER_SNOOP_EN
        ext_we[0] = 1'b1; ext_a[0] = 16'd17; ext_d[0] = 8'h9A;
        @(negedge clock);
        ext_we[0] = 1'b0;
        chk("inv_valid_pulse", 32'(inv_v[0]), 1);
        chk("inv_address", 32'(inv_a[0]), 16);
        @(negedge clock);
        chk("inv_valid_end", 32'(inv_v[0]), 0);
        txn(0, 1'b0, 8'h00, 16'd16, 1'b1, 16'h9A00, 0);
`else
        for (int d = 0; d < NDUT; d++) chk($sformatf("inv_tied_d%0d", d), {15'd0, inv_v[d], inv_a[d]}, 0);
`endif

        repeat (3) @(negedge clock);
        for (int d = 0; d < NDUT; d++) chk($sformatf("queue_empty_d%0d", d), exp_q[d].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the cache's miss/write-through channel.
- Accepts the 25-bit {we, data[7:0], addr[15:0]} request, reads or writes a byte-addressed backing store, and returns the aligned 16-bit block containing the addressed byte.
- Four-phase handshake with a programmable wait-state latency.
- Clears the store after reset; an optional external write port drives cache invalidation.

Parameters:
- ADDR_WIDTH, 16, byte-address width; the store holds 2**ADDR_WIDTH bytes.
- READ_LATENCY, 2, wait-state cycles between request acceptance and response; 0 is legal.
- CLEAR_ON_RESET, 1, when 1, zero the whole store after reset before accepting requests.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- memory_request  in  25  {we[24], data[23:16], addr[15:0]}; only addr[ADDR_WIDTH-1:0] is used.
- memory_request_ready  in  1  request valid; held high by the cache until it sees the response.
- memory_response  out  16  block {byte[addr|1], byte[addr&~1]}; the even byte is in bits [7:0].
- memory_response_ready  out  1  response valid.
- busy  out  1  high while the post-reset clear runs.
- invalidate_address  out  16  block address to invalidate in the cache (feature only).
- invalidate_valid  out  1  one-cycle qualifier for invalidate_address (feature only).

Behaviour:
- Reset values: memory_response=0, memory_response_ready=0, invalidate_address=0, invalidate_valid=0. busy=CLEAR_ON_RESET. FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
- CLEAR:
  - Writes 0 to two bytes per cycle, walking block 0 upward.
  - Lasts 2**(ADDR_WIDTH-1) cycles, then busy drops and the FSM goes to IDLE.
  - memory_request_ready is ignored during CLEAR; the request stays pending and is accepted on the first IDLE cycle.
- IDLE, on memory_request_ready=1 at edge k:
  - Latch the request.
  - If we=1, write the data byte to the store at edge k, so the returned block includes the new byte.
  - Go to WAIT if READ_LATENCY>0, otherwise RESPOND.
- WAIT:
  - Counter loads READ_LATENCY-1 and decrements each cycle.
  - At 0, go to RESPOND.
- RESPOND:
  - memory_response is registered from the store using the latched address.
  - memory_response_ready rises at edge k+1+READ_LATENCY.
  - Both stay stable while memory_request_ready=1.
  - On the edge where memory_request_ready=0, clear memory_response_ready and memory_response and go to IDLE.
  - The next request is accepted no earlier than the following edge (four-phase; back-to-back requests must drop ready for at least one cycle).
- Alignment: block base = addr & ~1. Requests for odd and even addresses of one block return identical data.
- Address 0xFFFF (ADDR_WIDTH=16) maps to block 0xFFFE. There is no wrap and no out-of-range access.
- Request fields that change while the FSM is not in IDLE are ignored. Only the latched copy is used.
- Reset asserted in any state, including mid-WAIT or mid-RESPOND:
  - Abort immediately and drop memory_response_ready the same edge.
  - Restart CLEAR; any partially written store contents are overwritten.
- Store is one write port plus one read port per cycle, implemented as a register array or inferred RAM.

Optional Feature:
- Macro: MEM_RESPONDER_SNOOP_EN.
- When defined, adds ports ext_write (in 1), ext_address (in 16) and ext_data (in 8), modelling another agent writing memory:
  - Each cycle with ext_write=1 and busy=0 writes ext_data to the store.
  - The next edge sets invalidate_address={ext_address[15:1],1'b0} and pulses invalidate_valid for one cycle.
  - ext_write during CLEAR is dropped, with no invalidate.
  - Same-cycle collision with a cache write to the same byte: the cache write wins; the invalidate still pulses.
  - An ext write to the block currently in WAIT is reflected in the response, because the read happens on entering RESPOND.
- When not defined: no ext ports; invalidate_address is tied to 0 and invalidate_valid to 0.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=8 -> busy high for exactly 128 cycles; reads of addr 0x00..0xFF all return 16'h0000.
- Write 55 to addr 12, read addr 13 -> write response 16'h0037; read 13 returns 16'h0037. Response-ready latency is 1+READ_LATENCY cycles for READ_LATENCY=0, 2 and 5.
- Write 0x22 to 0xFFFF then read 0xFFFE (ADDR_WIDTH=16, CLEAR_ON_RESET=0) -> both responses 16'h2200 (upper-byte placement).
- Hold memory_request_ready high for 10 cycles after response -> response and ready stable; drop ready -> memory_response_ready=0 next edge; new request accepted after a 1-cycle gap.
- Assert reset during WAIT of a read -> memory_response_ready never rises; busy reasserts; the pending request is served only after the clear.
- With MEM_RESPONDER_SNOOP_EN, ext write 0x9A to addr 17 -> invalidate_address=16 with a 1-cycle invalidate_valid pulse; a following read of 16 returns 16'h9A00.
